// File: rtl/spi_byte_engine_pkg.sv
// Shared definitions for the SPI byte engine: FSM encoding, CRC-8 constants and helper.
// The CRC helper is only referenced when SPI_FRAME_CRC_EN is defined.
package spi_byte_engine_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;
  localparam int         DEF_IDXW  = 5;
  localparam int         DEF_SYNC  = 2;

  // One full byte through CRC-8, MSB first.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/spi_byte_engine_sync.sv
// Synchroniser for one asynchronous SPI line plus single-cycle rise/fall pulses.
// Flops reset to 0 so a line already low at reset release never produces a fall.
module spi_sync_edge
  import spi_byte_engine_pkg::*;
#(
  parameter int SYNC = DEF_SYNC
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC-1:0] sync_q;
  logic            prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC-2:0], async_i};
      prev_q <= sync_q[SYNC-1];
    end
  end

  assign rise_o = sync_q[SYNC-1] & ~prev_q;
  assign fall_o = ~sync_q[SYNC-1] & prev_q;

endmodule

// File: rtl/spi_byte_engine.sv
// SPI-slave (mode 0, MSB first) byte layer: indexed rx bytes, indexed tx readback, frame pulses.
// Define SPI_FRAME_CRC_EN to check a trailing CRC-8 byte and report it on crc_ok.
module spi_byte_engine
  import spi_byte_engine_pkg::*;
#(
  parameter int IDXW = DEF_IDXW,
  parameter int SYNC = DEF_SYNC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            SCK,
  input  logic            SSEL,
  input  logic            MOSI,
  output logic            MISO,
  output logic [7:0]      rx_byte,
  output logic [IDXW-1:0] rx_idx,
  output logic            rx_valid,
  output logic [IDXW-1:0] tx_idx,
  input  logic [7:0]      tx_data,
  output logic            frame_start,
  output logic            frame_end,
  output logic            frame_err,
  output logic            crc_ok,
  output logic            active
);

  localparam logic [IDXW-1:0] IDX_MAX = {IDXW{1'b1}};
  localparam logic [IDXW-1:0] IDX_ONE = {{(IDXW-1){1'b0}}, 1'b1};

  logic sck_rise, sck_fall, ssel_rise, ssel_fall;

  spi_sync_edge #(.SYNC(SYNC)) u_sck_sync (
    .clk(clk), .rst(rst), .async_i(SCK), .rise_o(sck_rise), .fall_o(sck_fall)
  );

  spi_sync_edge #(.SYNC(SYNC)) u_ssel_sync (
    .clk(clk), .rst(rst), .async_i(SSEL), .rise_o(ssel_rise), .fall_o(ssel_fall)
  );

  // Same depth as the SCK synchroniser, so mosi_s is the level captured with the detected rise.
  logic [SYNC-1:0] mosi_sync_q;
  logic            mosi_s;

  always_ff @(posedge clk) begin
    if (rst) mosi_sync_q <= '0;
    else     mosi_sync_q <= {mosi_sync_q[SYNC-2:0], MOSI};
  end

  assign mosi_s = mosi_sync_q[SYNC-1];

  state_e          state_q;
  logic [2:0]      bit_cnt_q;
  logic [IDXW-1:0] byte_idx_q;
  logic [1:0]      load_cnt_q;
  logic            byte_done_q;
  logic [6:0]      rx_sr_q;
  logic [7:0]      tx_sr_q;
  logic [7:0]      rx_byte_q;
  logic [IDXW-1:0] rx_idx_q;
  logic            rx_valid_q, frame_start_q, frame_end_q, frame_err_q, crc_ok_q;
  logic [7:0]      rx_full;
`ifdef SPI_FRAME_CRC_EN
  logic [7:0]      crc_q;
`endif

  assign rx_full = {rx_sr_q, mosi_s};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      bit_cnt_q     <= 3'd0;
      byte_idx_q    <= '0;
      load_cnt_q    <= 2'd0;
      byte_done_q   <= 1'b0;
      rx_sr_q       <= 7'd0;
      tx_sr_q       <= 8'd0;
      rx_byte_q     <= 8'd0;
      rx_idx_q      <= '0;
      rx_valid_q    <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      frame_err_q   <= 1'b0;
      crc_ok_q      <= 1'b0;
`ifdef SPI_FRAME_CRC_EN
      crc_q         <= CRC8_INIT;
`endif
    end else begin
      rx_valid_q    <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      frame_err_q   <= 1'b0;
      crc_ok_q      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (ssel_fall) begin
            state_q       <= ST_ACTIVE;
            frame_start_q <= 1'b1;
            bit_cnt_q     <= 3'd0;
            byte_idx_q    <= '0;
            load_cnt_q    <= 2'd2;
            byte_done_q   <= 1'b0;
`ifdef SPI_FRAME_CRC_EN
            crc_q         <= CRC8_INIT;
`endif
          end
        end
        ST_ACTIVE: begin
          // Give downstream two cycles to present tx_data for index 0.
          if (load_cnt_q != 2'd0) begin
            load_cnt_q <= load_cnt_q - 2'd1;
            if (load_cnt_q == 2'd1) tx_sr_q <= tx_data;
          end
          if (ssel_rise) begin
            state_q     <= ST_IDLE;
            frame_end_q <= 1'b1;
            frame_err_q <= (bit_cnt_q != 3'd0);
`ifdef SPI_FRAME_CRC_EN
            crc_ok_q    <= (bit_cnt_q == 3'd0) && (crc_q == 8'h00);
`else
            crc_ok_q    <= (bit_cnt_q == 3'd0);
`endif
            bit_cnt_q   <= 3'd0;
            load_cnt_q  <= 2'd0;
            byte_done_q <= 1'b0;
            tx_sr_q     <= 8'd0;
          end else if (sck_rise) begin
            rx_sr_q   <= rx_full[6:0];
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              rx_valid_q  <= 1'b1;
              rx_byte_q   <= rx_full;
              rx_idx_q    <= byte_idx_q;
              byte_done_q <= 1'b1;
              if (byte_idx_q != IDX_MAX) byte_idx_q <= byte_idx_q + IDX_ONE;
`ifdef SPI_FRAME_CRC_EN
              crc_q       <= crc8_byte(crc_q, rx_full);
`endif
            end
          end else if (sck_fall) begin
            if (byte_done_q) begin
              tx_sr_q     <= tx_data;
              byte_done_q <= 1'b0;
            end else begin
              tx_sr_q <= {tx_sr_q[6:0], 1'b0};
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign MISO        = tx_sr_q[7];
  assign rx_byte     = rx_byte_q;
  assign rx_idx      = rx_idx_q;
  assign rx_valid    = rx_valid_q;
  assign tx_idx      = byte_idx_q;
  assign frame_start = frame_start_q;
  assign frame_end   = frame_end_q;
  assign frame_err   = frame_err_q;
  assign crc_ok      = crc_ok_q;
  assign active      = (state_q == ST_ACTIVE);

endmodule

// File: doc/spi_byte_engine.md
Name: spi_byte_engine

Overview:
- SPI-slave byte layer (mode 0, MSB first) that feeds the register-map/decode stage directly downstream, which owns the velocity, output-pin, timing and PWM registers.
- Synchronises SCK/SSEL/MOSI to clk, deserialises MOSI into indexed bytes, serialises indexed readback bytes onto MISO, and reports frame start, end and error.
- Downstream sees only single-cycle pulses plus byte indices, never raw SPI edges.

Parameters:
IDXW, 5, width of the byte index within a frame
SYNC, 2, synchroniser depth for SCK/SSEL/MOSI (min 2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
SCK  in  1  SPI clock, asynchronous
SSEL  in  1  SPI select, active low, asynchronous
MOSI  in  1  SPI data in, asynchronous
MISO  out  1  SPI data out
rx_byte  out  8  last complete received byte
rx_idx  out  IDXW  index of rx_byte in current frame
rx_valid  out  1  one-cycle pulse: rx_byte/rx_idx valid
tx_idx  out  IDXW  index of the byte to be transmitted next
tx_data  in  8  readback byte for tx_idx
frame_start  out  1  one-cycle pulse on SSEL assertion
frame_end  out  1  one-cycle pulse on SSEL deassertion
frame_err  out  1  with frame_end: frame ended mid-byte
crc_ok  out  1  with frame_end: frame integrity result
active  out  1  high while in ACTIVE state

Behaviour:
- Reset: all outputs 0, state IDLE, bit counter 0, byte index 0, tx shift register 0. SSEL already low at reset release is not a start; wait for a synchronised high-to-low transition.
- Synchronisation: SYNC flops plus one edge-detect flop per input. MOSI is delayed to align with the SCK edge sample.
- Timing requirements on the master: SCK half-period ≥ SYNC+2 clk. SSEL-fall to first SCK rise ≥ SYNC+3 clk.
- FSM IDLE -> ACTIVE on synchronised SSEL fall:
  - frame_start pulses.
  - bit counter and byte index cleared; tx_idx = 0.
  - 2 clk later the tx shift register loads tx_data.
- In ACTIVE:
  - SCK rise: shift MOSI in; increment bit counter.
  - Eighth rise: next cycle rx_valid=1, rx_byte=assembled byte, rx_idx=current index. Byte index then increments and tx_idx follows in the same cycle.
  - SCK fall: shift tx register left, MISO = bit 7.
  - Fall following a completed byte: load tx_data for the new tx_idx instead of shifting. Downstream may register tx_data off tx_idx with ≤2 clk latency.
- Byte index saturates at 2^IDXW-1. Further bytes are still delivered with that index; tx keeps sending tx_data for that index.
- ACTIVE -> IDLE on synchronised SSEL rise:
  - frame_end pulses.
  - frame_err=1 in that cycle if bit counter ≠ 0; the partial byte is discarded with no rx_valid.
  - MISO forced 0.
- Simultaneous SSEL rise and SCK edge in one cycle: SSEL wins, edge ignored.
- SCK edges in IDLE are ignored.
- rst mid-frame aborts silently: no frame_end.
- rx_byte/rx_idx hold between pulses. frame_err and crc_ok are 0 outside the frame_end cycle.

Optional Feature:
- SPI_FRAME_CRC_EN defined:
  - CRC-8, poly 0x07, init 0x00, MSB first, updated on every rx_valid; reset to 0x00 at frame_start.
  - At frame_end, crc_ok=1 iff running CRC == 0x00 and frame_err=0. The master appends the CRC of the preceding bytes as the last byte.
- Undefined: crc_ok = ~frame_err during frame_end; no CRC logic synthesised.

Decomposition:
- Shared package: state encoding (IDLE, ACTIVE), CRC8_POLY=8'h07, CRC8_INIT=8'h00, default IDXW.
- One natural sub-module: spi_sync_edge (synchroniser plus rise/fall pulse generator), instantiated for SCK and SSEL. MOSI uses its delay-only path.

Test Plan:
- rst high 3 clk with SSEL low, release, clock byte 0xA5 -> no frame_start, no rx_valid.
- SSEL fall, send 0x12 0x34 0x56, tx_data = 0xC0|tx_idx -> rx_valid ×3 with (0x12,0), (0x34,1), (0x56,2). MISO returns 0xC0, 0xC1, 0xC2. frame_end=1, frame_err=0.
- Frame of 8 bytes + 3 bits then SSEL rise -> 8 rx_valid, frame_end with frame_err=1, no ninth rx_valid.
- 40-byte frame with IDXW=5 -> rx_idx 0..31 then 31 for bytes 32–39, no wrap to 0.
- SPI_FRAME_CRC_EN: send 0x01 0x02 0x1B -> crc_ok=1. Corrupt last byte to 0x1A -> crc_ok=0.
- SSEL rise coincident with the 8th SCK rise -> no rx_valid, frame_err=1; rst asserted mid-frame -> no frame_end, MISO=0.
